uart_rx_frame_ctrl: RTL and testbench

Frame-level controller that sits directly behind the UART receiver and sequences its byte output into framed packets. It consumes the receiver's one-cycle RX_Done strobe and RX_Bytes value. It hunts for a sync byte, takes a length byte, streams the payload out with an index, and checks an additive checksum. Each frame ends in either a Frame_Done pulse or a Frame_Error pulse with a code; inter-byte stalls are caught by a timeout.

---
 rtl/uart_rx_frame_ctrl_if.sv | 45 ++++
 rtl/uart_rx_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-in / payload-out signal bundle between the UART receiver side and the frame controller.
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned IDX_W = 4
);

  logic             Enable;
  logic             RX_Done;
  logic [7:0]       RX_Bytes;
  logic             Payload_Valid;
  logic [7:0]       Payload_Byte;
  logic [IDX_W-1:0] Payload_Index;
  logic             Frame_Done;
  logic             Frame_Error;
  logic [1:0]       Error_Code;
  logic             Busy;

  // Receiver / host side: supplies bytes, consumes payload and frame status.
  modport master (
    output Enable,
    output RX_Done,
    output RX_Bytes,
    input  Payload_Valid,
    input  Payload_Byte,
    input  Payload_Index,
    input  Frame_Done,
    input  Frame_Error,
    input  Error_Code,
    input  Busy
  );

  // Frame controller side.
  modport slave (
    input  Enable,
    input  RX_Done,
    input  RX_Bytes,
    output Payload_Valid,
    output Payload_Byte,
    output Payload_Index,
    output Frame_Done,
    output Frame_Error,
    output Error_Code,
    output Busy
  );

endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: SYNC, LEN, payload, additive checksum, inter-byte timeout.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 86800
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  uart_rx_frame_ctrl_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] EC_BAD_LEN = 2'b01;
  localparam logic [1:0] EC_CKSUM   = 2'b10;
  localparam logic [1:0] EC_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CKSUM   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             pv_q, pv_d;
  logic [7:0]       pbyte_q, pbyte_d;
  logic [IDX_W-1:0] pidx_q, pidx_d;
  logic             fd_q, fd_d;
  logic             fe_q, fe_d;
  logic [1:0]       ec_q, ec_d;
  logic             busy_q, busy_d;

  // State, datapath and registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      tmr_q   <= '0;
      pv_q    <= 1'b0;
      pbyte_q <= '0;
      pidx_q  <= '0;
      fd_q    <= 1'b0;
      fe_q    <= 1'b0;
      ec_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      tmr_q   <= tmr_d;
      pv_q    <= pv_d;
      pbyte_q <= pbyte_d;
      pidx_q  <= pidx_d;
      fd_q    <= fd_d;
      fe_q    <= fe_d;
      ec_q    <= ec_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and output decode; a byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    tmr_d   = tmr_q;
    pv_d    = 1'b0;
    pbyte_d = pbyte_q;
    pidx_d  = pidx_q;
    fd_d    = 1'b0;
    fe_d    = 1'b0;
    ec_d    = ec_q;

    if (!bus.Enable) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else if (bus.RX_Done) begin
      tmr_d = '0;
      case (state_q)
        IDLE: begin
          if (bus.RX_Bytes == SYNC_BYTE) begin
            state_d = LEN;
          end
        end
        LEN: begin
          if ((bus.RX_Bytes == 8'd0) || (bus.RX_Bytes > 8'(MAX_LEN))) begin
            fe_d    = 1'b1;
            ec_d    = EC_BAD_LEN;
            state_d = IDLE;
          end else begin
            len_d   = LEN_W'(bus.RX_Bytes);
            sum_d   = bus.RX_Bytes;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pv_d    = 1'b1;
          pbyte_d = bus.RX_Bytes;
          pidx_d  = IDX_W'(cnt_q);
          sum_d   = sum_q + bus.RX_Bytes;
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_q == (len_q - LEN_W'(1))) begin
            state_d = CKSUM;
          end
        end
        CKSUM: begin
          if (bus.RX_Bytes == sum_q) begin
            fd_d = 1'b1;
          end else begin
            fe_d = 1'b1;
            ec_d = EC_CKSUM;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmr_q == TMR_LAST) begin
        fe_d    = 1'b1;
        ec_d    = EC_TIMEOUT;
        state_d = IDLE;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end else begin
      tmr_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // Registered outputs onto the bus.
  assign bus.Payload_Valid = pv_q;
  assign bus.Payload_Byte  = pbyte_q;
  assign bus.Payload_Index = pidx_q;
  assign bus.Frame_Done    = fd_q;
  assign bus.Frame_Error   = fe_q;
  assign bus.Error_Code    = ec_q;
  assign bus.Busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: vector tables per frame plus hand-written reset/enable/timeout sequences.
module tb_uart_rx_frame_ctrl;

  logic clk;
  logic rst_n;

  uart_rx_frame_ctrl_if #(.IDX_W(4)) a_if ();
  uart_rx_frame_ctrl_if #(.IDX_W(4)) b_if ();

  // Default-timeout instance for frame traffic.
  uart_rx_frame_ctrl dut_a (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (a_if.slave)
  );

  // Short-timeout instance for the stall cases.
  uart_rx_frame_ctrl #(.TIMEOUT_CLKS(100)) dut_b (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per RX_Done strobe: gap idle cycles, then the byte, then expected outputs one clock later.
  typedef struct {
    logic [7:0] b;
    int         gap;
    logic       pv;
    logic [7:0] pb;
    logic [3:0] pi;
    logic       fd;
    logic       fe;
    logic [1:0] ec;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_viol = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] b, input int gap, input logic pv, input logic [7:0] pb,
                              input logic [3:0] pi, input logic fd, input logic fe, input logic [1:0] ec,
                              input logic busy);
    vec_t v;
    v.b = b; v.gap = gap; v.pv = pv; v.pb = pb; v.pi = pi;
    v.fd = fd; v.fe = fe; v.ec = ec; v.busy = busy;
    tbl.push_back(v);
  endfunction

  // Packed view {pv, pb, pi, fd, fe, ec, busy} of one instance.
  function automatic logic [17:0] obs(input bit sel);
    if (sel)
      return {b_if.Payload_Valid, b_if.Payload_Byte, b_if.Payload_Index, b_if.Frame_Done,
              b_if.Frame_Error, b_if.Error_Code, b_if.Busy};
    return {a_if.Payload_Valid, a_if.Payload_Byte, a_if.Payload_Index, a_if.Frame_Done,
            a_if.Frame_Error, a_if.Error_Code, a_if.Busy};
  endfunction

  function automatic logic pulses(input bit sel);
    if (sel) return b_if.Payload_Valid | b_if.Frame_Done | b_if.Frame_Error;
    return a_if.Payload_Valid | a_if.Frame_Done | a_if.Frame_Error;
  endfunction

  // Drive one clock of input (from a falling edge) and return at the next falling edge.
  task automatic step(input bit sel, input logic rxd, input logic [7:0] b);
    if (sel) begin b_if.RX_Done = rxd; b_if.RX_Bytes = b; end
    else     begin a_if.RX_Done = rxd; a_if.RX_Bytes = b; end
    @(negedge clk);
  endtask

  task automatic run_table(input bit sel, input string name);
    logic [17:0] exp;
    bit quiet;
    for (int i = 0; i < tbl.size(); i++) begin
      quiet = 1'b1;
      for (int g = 0; g < tbl[i].gap; g++) begin
        step(sel, 1'b0, 8'h00);
        if (pulses(sel)) quiet = 1'b0;
      end
      if (tbl[i].gap > 0) cmp($sformatf("%s[%0d].gap_quiet", name, i), 32'(quiet), 32'd1);
      step(sel, 1'b1, tbl[i].b);
      exp = {tbl[i].pv, tbl[i].pb, tbl[i].pi, tbl[i].fd, tbl[i].fe, tbl[i].ec, tbl[i].busy};
      cmp($sformatf("%s[%0d].byte_%02h", name, i, tbl[i].b), 32'(obs(sel)), 32'(exp));
    end
    if (sel) b_if.RX_Done = 1'b0; else a_if.RX_Done = 1'b0;
    tbl.delete();
  endtask

  // Pulse exclusivity on both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((a_if.Frame_Done && a_if.Frame_Error) || (a_if.Payload_Valid && (a_if.Frame_Done || a_if.Frame_Error)))
        n_viol++;
      if ((b_if.Frame_Done && b_if.Frame_Error) || (b_if.Payload_Valid && (b_if.Frame_Done || b_if.Frame_Error)))
        n_viol++;
    end
  end

  initial begin
    int  n_tmo;
    bit  quiet;
    rst_n = 1'b0;
    a_if.Enable = 1'b1; a_if.RX_Done = 1'b0; a_if.RX_Bytes = 8'h00;
    b_if.Enable = 1'b1; b_if.RX_Done = 1'b0; b_if.RX_Bytes = 8'h00;
    repeat (3) @(negedge clk);
    cmp("reset_a", 32'(obs(0)), 32'd0);
    cmp("reset_b", 32'(obs(1)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, one byte time between strobes.
    add(8'hA5, 8679, 0, 8'h00, 0, 0, 0, 2'd0, 1);
    add(8'h03, 8679, 0, 8'h00, 0, 0, 0, 2'd0, 1);
    add(8'h11, 8679, 1, 8'h11, 0, 0, 0, 2'd0, 1);
    add(8'h22, 8679, 1, 8'h22, 1, 0, 0, 2'd0, 1);
    add(8'h33, 8679, 1, 8'h33, 2, 0, 0, 2'd0, 1);
    add(8'h69, 8679, 0, 8'h33, 2, 1, 0, 2'd0, 0);
    run_table(0, "good");

    // Bad checksum.
    add(8'hA5, 4, 0, 8'h33, 2, 0, 0, 2'd0, 1);
    add(8'h03, 4, 0, 8'h33, 2, 0, 0, 2'd0, 1);
    add(8'h11, 4, 1, 8'h11, 0, 0, 0, 2'd0, 1);
    add(8'h22, 4, 1, 8'h22, 1, 0, 0, 2'd0, 1);
    add(8'h33, 4, 1, 8'h33, 2, 0, 0, 2'd0, 1);
    add(8'h68, 4, 0, 8'h33, 2, 0, 1, 2'd2, 0);
    run_table(0, "badsum");

    // Zero length and length above MAX_LEN.
    add(8'hA5, 3, 0, 8'h33, 2, 0, 0, 2'd2, 1);
    add(8'h00, 3, 0, 8'h33, 2, 0, 1, 2'd1, 0);
    add(8'hA5, 3, 0, 8'h33, 2, 0, 0, 2'd1, 1);
    add(8'h11, 3, 0, 8'h33, 2, 0, 1, 2'd1, 0);
    run_table(0, "badlen");

    // Junk before sync, then a frame on consecutive clocks with SYNC as payload data.
    add(8'h00, 3, 0, 8'h33, 2, 0, 0, 2'd1, 0);
    add(8'hFF, 3, 0, 8'h33, 2, 0, 0, 2'd1, 0);
    add(8'h37, 3, 0, 8'h33, 2, 0, 0, 2'd1, 0);
    add(8'hA5, 3, 0, 8'h33, 2, 0, 0, 2'd1, 1);
    add(8'h01, 0, 0, 8'h33, 2, 0, 0, 2'd1, 1);
    add(8'hA5, 0, 1, 8'hA5, 0, 0, 0, 2'd1, 1);
    add(8'hA6, 0, 0, 8'hA5, 0, 1, 0, 2'd1, 0);
    run_table(0, "b2b");

    // Timeout instance: strobes landing exactly on the expiry cycle keep the frame alive.
    add(8'hA5, 2,  0, 8'h00, 0, 0, 0, 2'd0, 1);
    add(8'h02, 99, 0, 8'h00, 0, 0, 0, 2'd0, 1);
    add(8'h44, 99, 1, 8'h44, 0, 0, 0, 2'd0, 1);
    run_table(1, "tmo");
    n_tmo = 0;
    quiet = 1'b1;
    for (int i = 1; i <= 200 && n_tmo == 0; i++) begin
      step(1, 1'b0, 8'h00);
      if (b_if.Frame_Error) n_tmo = i;
      else if (b_if.Payload_Valid || b_if.Frame_Done) quiet = 1'b0;
    end
    cmp("tmo_latency", 32'(n_tmo), 32'd100);
    cmp("tmo_code", 32'(b_if.Error_Code), 32'd3);
    cmp("tmo_busy", 32'(b_if.Busy), 32'd0);
    cmp("tmo_quiet", 32'(quiet), 32'd1);

    // Reset in the middle of a frame.
    add(8'hA5, 2, 0, 8'hA5, 0, 0, 0, 2'd1, 1);
    add(8'h03, 2, 0, 8'hA5, 0, 0, 0, 2'd1, 1);
    add(8'h11, 2, 1, 8'h11, 0, 0, 0, 2'd1, 1);
    run_table(0, "pre_rst");
    rst_n = 1'b0;
    #1;
    cmp("midrst_async", 32'(obs(0)), 32'd0);
    @(negedge clk);
    cmp("midrst_held", 32'(obs(0)), 32'd0);
    rst_n = 1'b1;
    add(8'hA5, 2, 0, 8'h00, 0, 0, 0, 2'd0, 1);
    add(8'h01, 2, 0, 8'h00, 0, 0, 0, 2'd0, 1);
    add(8'h7E, 2, 1, 8'h7E, 0, 0, 0, 2'd0, 1);
    add(8'h7F, 2, 0, 8'h7E, 0, 1, 0, 2'd0, 0);
    run_table(0, "post_rst");

    // Enable dropped mid-frame: Busy falls, strobes are ignored, outputs hold.
    add(8'hA5, 2, 0, 8'h7E, 0, 0, 0, 2'd0, 1);
    add(8'h02, 2, 0, 8'h7E, 0, 0, 0, 2'd0, 1);
    add(8'h10, 2, 1, 8'h10, 0, 0, 0, 2'd0, 1);
    run_table(0, "pre_en");
    a_if.Enable = 1'b0;
    step(0, 1'b0, 8'h00);
    cmp("en_off_busy", 32'(obs(0)), 32'({1'b0, 8'h10, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0}));
    quiet = 1'b1;
    step(0, 1'b1, 8'h20); if (pulses(0) || a_if.Busy) quiet = 1'b0;
    step(0, 1'b1, 8'hA5); if (pulses(0) || a_if.Busy) quiet = 1'b0;
    step(0, 1'b1, 8'h01); if (pulses(0) || a_if.Busy) quiet = 1'b0;
    a_if.RX_Done = 1'b0;
    cmp("en_off_quiet", 32'(quiet), 32'd1);
    cmp("en_off_hold", 32'(obs(0)), 32'({1'b0, 8'h10, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0}));
    a_if.Enable = 1'b1;
    add(8'hA5, 2, 0, 8'h10, 0, 0, 0, 2'd0, 1);
    add(8'h01, 2, 0, 8'h10, 0, 0, 0, 2'd0, 1);
    add(8'h05, 2, 1, 8'h05, 0, 0, 0, 2'd0, 1);
    add(8'h06, 2, 0, 8'h05, 0, 1, 0, 2'd0, 0);
    run_table(0, "en_on");

    repeat (2) @(negedge clk);
    cmp("pulse_exclusive", 32'(n_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
